if_id_stage: RTL and testbench
==============================

// Module: if_id_stage
// PURPOSE
// - IF/ID pipeline stage between the instruction fetch unit and decode.
// - Registers Instruction/PC+4/PC from fetch; detects load-use hazards against ID/EX; resolves j/jal/jr in ID.
// - Drives PCWrite_40, Jump_40 and NewPC back to fetch. Squashes the wrong-path fetch on a jump or on an EX branch flush.
// PARAMETERS
// - NOP_INSTR   32'h0000_0000   instruction word loaded on squash/reset
// - CNT_W       32              width of the stall performance counter (optional feature)
// PORTS
// - Clk_40            in   1   clock, all state on rising edge
// - Reset_40          in   1   synchronous, active-high reset
// - Instruction_40    in   32  fetched instruction
// - PCNext4_40        in   32  PC+4 of fetched instruction
// - PCNow_40          in   32  PC of fetched instruction
// - Freeze_40         in   1   global pipeline freeze (memory wait); holds everything
// - Flush_40          in   1   EX branch taken; squash IF/ID contents
// - IDEX_MemRead_40   in   1   instruction in EX is a load
// - IDEX_Rt_40        in   5   load destination register in EX
// - RsData_40         in   32  forwarded rs value for jr target
// - PCWrite_40        out  1   PC enable to fetch
// - Jump_40           out  1   select NewPC in fetch
// - NewPC             out  32  jump target
// - IFID_Instr_40     out  32  registered instruction to decode
// - IFID_PCNext4_40   out  32  registered PC+4
// - IFID_PCNow_40     out  32  registered PC
// - IFID_Valid_40     out  1   1 = real instruction to decode; 0 = bubble
// BEHAVIOUR
// - State: Instr_q, PCNext4_q, PCNow_q, Valid_q. Reset: Instr_q=NOP_INSTR, PCs=0, Valid_q=0.
// - Reset outputs: IFID_*=0/NOP, IFID_Valid_40=0, Jump_40=0, NewPC=0, PCWrite_40=1.
// - Decode of Instr_q: op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0].
// - UsesRs = op!=2 && op!=3. UsesRt = op==0 || op==4 || op==5 || op==43.
// - Hazard = Valid_q & IDEX_MemRead_40 & IDEX_Rt_40!=0 & ((UsesRs & rs==IDEX_Rt_40) | (UsesRt & rt==IDEX_Rt_40)).
// - JumpDet = Valid_q & (op==2 | op==3 | (op==0 & funct==6'h08)).
// - Jump_40 = JumpDet & ~Hazard & ~Freeze_40 & ~Flush_40 (combinational).
// - NewPC: j/jal = {PCNext4_q[31:28], Instr_q[25:0], 2'b00}; jr = RsData_40; else 0.
// - PCWrite_40 = ~(Hazard | Freeze_40).
// - IFID_Valid_40 = Valid_q & ~Hazard (hazard cycle presents a bubble to ID/EX).
// - Register update priority each edge (highest first):
//   1 Reset_40: reset values.
//   2 Freeze_40: hold all regs (overrides flush; flush must be re-presented after freeze).
//   3 Flush_40: Instr_q=NOP_INSTR, Valid_q=0, PCs hold.
//   4 Jump_40: squash (as 3) -- the fetched word is wrong path; fetch loads NewPC same edge.
//   5 Hazard: hold all regs (1 bubble per cycle of hazard; clears when load leaves EX).
//   6 otherwise: load Instruction_40/PCNext4_40/PCNow_40, Valid_q=1.
// - Latency: fetch-to-decode 1 cycle. Jump penalty 1 bubble. Load-use penalty 1 bubble.
// - Flush and hazard in same cycle: flush wins, no stall asserted on register side.
// - jr with hazard on rs: Jump_40 held 0 until hazard clears, then target taken.
// - Reset mid-stall/mid-jump: next cycle all state reset, no pending jump retained.
// CONFIGURATION
// - IFID_PERF_CNT_EN defined: adds output StallCnt_40 [CNT_W-1:0]; reset 0; +1 on each
//   cycle with Hazard & ~Freeze_40; +1 on each squash (Flush_40 or Jump_40) & ~Freeze_40;
//   saturates at all-ones (no wrap).
// - Undefined: port and counter absent; behaviour otherwise identical.
// TESTING
// - Reset 2 cycles, then fetch 0x2009_0005 @PC 0x0 -> next cycle IFID_Instr_40=0x20090005, Valid=1, PCNext4=0x4.
// - IFID holds add $3,$1,$2 (0x0022_1820), IDEX_MemRead=1, Rt=2 -> PCWrite=0, IFID_Valid=0 1 cycle, regs held; Rt=0 -> no stall.
// - IFID holds j 0x100 (0x0800_0040), PCNext4=0x1000_0008 -> Jump=1, NewPC=0x1000_0100; next cycle Valid=0, Instr=NOP.
// - jr $31 with RsData=0x0000_0400 -> NewPC=0x400, Jump=1; with same-cycle hazard on rs=31 -> Jump=0, PCWrite=0.
// - Flush_40=1 with Freeze_40=1 -> regs held; Freeze then 0 & Flush 1 -> Valid=0, Instr=NOP.
// - IFID_PERF_CNT_EN: 3 hazard cycles + 1 jump -> StallCnt_40=4; preset near max -> sticks at all-ones.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection and j/jal/jr resolution in decode.
// Optional stall/squash performance counter enabled by defining IFID_PERF_CNT_EN.
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic              Clk_40,
  input  logic              Reset_40,
  input  logic [31:0]       Instruction_40,
  input  logic [31:0]       PCNext4_40,
  input  logic [31:0]       PCNow_40,
  input  logic              Freeze_40,
  input  logic              Flush_40,
  input  logic              IDEX_MemRead_40,
  input  logic [4:0]        IDEX_Rt_40,
  input  logic [31:0]       RsData_40,
  output logic              PCWrite_40,
  output logic              Jump_40,
  output logic [31:0]       NewPC,
  output logic [31:0]       IFID_Instr_40,
  output logic [31:0]       IFID_PCNext4_40,
  output logic [31:0]       IFID_PCNow_40,
`ifdef IFID_PERF_CNT_EN
  output logic [CNT_W-1:0]  StallCnt_40,
`endif
  output logic              IFID_Valid_40
);

  logic [31:0] instr_q;
  logic [31:0] pc_next4_q;
  logic [31:0] pc_now_q;
  logic        valid_q;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       uses_rs;
  logic       uses_rt;
  logic       hazard;
  logic       is_j;
  logic       is_jr;
  logic       jump_det;
  logic       squash;

  assign op    = instr_q[31:26];
  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];
  assign funct = instr_q[5:0];

  assign uses_rs = (op != 6'd2) && (op != 6'd3);
  assign uses_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);

  assign hazard = valid_q && IDEX_MemRead_40 && (IDEX_Rt_40 != 5'd0) &&
                  ((uses_rs && (rs == IDEX_Rt_40)) || (uses_rt && (rt == IDEX_Rt_40)));

  assign is_j     = (op == 6'd2) || (op == 6'd3);
  assign is_jr    = (op == 6'd0) && (funct == 6'h08);
  assign jump_det = valid_q && (is_j || is_jr);

  // A jump waits out any load-use hazard so jr never uses a stale rs value.
  assign Jump_40 = jump_det && !hazard && !Freeze_40 && !Flush_40;
  assign squash  = Flush_40 || Jump_40;

  always_comb begin
    NewPC = 32'h0;
    if (is_j)
      NewPC = {pc_next4_q[31:28], instr_q[25:0], 2'b00};
    else if (is_jr)
      NewPC = RsData_40;
  end

  assign PCWrite_40      = !(hazard || Freeze_40);
  assign IFID_Valid_40   = valid_q && !hazard;
  assign IFID_Instr_40   = instr_q;
  assign IFID_PCNext4_40 = pc_next4_q;
  assign IFID_PCNow_40   = pc_now_q;

  always_ff @(posedge Clk_40) begin
    if (Reset_40) begin
      instr_q    <= NOP_INSTR;
      pc_next4_q <= 32'h0;
      pc_now_q   <= 32'h0;
      valid_q    <= 1'b0;
    end else if (Freeze_40) begin
      instr_q    <= instr_q;
      pc_next4_q <= pc_next4_q;
      pc_now_q   <= pc_now_q;
      valid_q    <= valid_q;
    end else if (squash) begin
      // Wrong-path word is discarded; PCs are kept only for visibility.
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!hazard) begin
      instr_q    <= Instruction_40;
      pc_next4_q <= PCNext4_40;
      pc_now_q   <= PCNow_40;
      valid_q    <= 1'b1;
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       cnt_inc;
  logic [CNT_W:0]   cnt_sum;

  // Hazard and flush can coincide, so up to two events are counted per cycle.
  assign cnt_inc = Freeze_40 ? 2'd0 : ({1'b0, hazard} + {1'b0, squash});
  assign cnt_sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, cnt_inc};

  always_ff @(posedge Clk_40) begin
    if (Reset_40)
      cnt_q <= '0;
    else if (cnt_sum[CNT_W])
      cnt_q <= '1;
    else
      cnt_q <= cnt_sum[CNT_W-1:0];
  end

  assign StallCnt_40 = cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, fetch, load-use stall, j/jal/jr, flush/freeze, reset mid-jump.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, pc_next4, pc_now, rs_data;
  logic        freeze, flush, idex_memread;
  logic [4:0]  idex_rt;
  logic        pc_write, jump, ifid_valid;
  logic [31:0] new_pc, ifid_instr, ifid_pc_next4, ifid_pc_now;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [1:0]  stall_cnt_small;
  logic        pc_write_s, jump_s, ifid_valid_s;
  logic [31:0] new_pc_s, ifid_instr_s, ifid_pc_next4_s, ifid_pc_now_s;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .Clk_40          (clk),
    .Reset_40        (rst),
    .Instruction_40  (instruction),
    .PCNext4_40      (pc_next4),
    .PCNow_40        (pc_now),
    .Freeze_40       (freeze),
    .Flush_40        (flush),
    .IDEX_MemRead_40 (idex_memread),
    .IDEX_Rt_40      (idex_rt),
    .RsData_40       (rs_data),
    .PCWrite_40      (pc_write),
    .Jump_40         (jump),
    .NewPC           (new_pc),
    .IFID_Instr_40   (ifid_instr),
    .IFID_PCNext4_40 (ifid_pc_next4),
    .IFID_PCNow_40   (ifid_pc_now),
`ifdef IFID_PERF_CNT_EN
    .StallCnt_40     (stall_cnt),
`endif
    .IFID_Valid_40   (ifid_valid)
  );

`ifdef IFID_PERF_CNT_EN
  // Narrow counter copy to observe saturation quickly.
  if_id_stage #(.CNT_W(2)) dut_small (
    .Clk_40          (clk),
    .Reset_40        (rst),
    .Instruction_40  (instruction),
    .PCNext4_40      (pc_next4),
    .PCNow_40        (pc_now),
    .Freeze_40       (freeze),
    .Flush_40        (flush),
    .IDEX_MemRead_40 (idex_memread),
    .IDEX_Rt_40      (idex_rt),
    .RsData_40       (rs_data),
    .PCWrite_40      (pc_write_s),
    .Jump_40         (jump_s),
    .NewPC           (new_pc_s),
    .IFID_Instr_40   (ifid_instr_s),
    .IFID_PCNext4_40 (ifid_pc_next4_s),
    .IFID_PCNow_40   (ifid_pc_now_s),
    .StallCnt_40     (stall_cnt_small),
    .IFID_Valid_40   (ifid_valid_s)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one edge, then let outputs settle before checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instruction = 32'h0; pc_next4 = 32'h0; pc_now = 32'h0; rs_data = 32'h0;
    freeze = 1'b0; flush = 1'b0; idex_memread = 1'b0; idex_rt = 5'd0;
    tick(); tick();
    chk("rst_instr",   ifid_instr, 32'h0);
    chk("rst_pcn4",    ifid_pc_next4, 32'h0);
    chk("rst_pcnow",   ifid_pc_now, 32'h0);
    chk("rst_valid",   ifid_valid, 32'h0);
    chk("rst_jump",    jump, 32'h0);
    chk("rst_newpc",   new_pc, 32'h0);
    chk("rst_pcwrite", pc_write, 32'h1);

    // Plain fetch
    rst = 1'b0; instruction = 32'h2009_0005; pc_next4 = 32'h4; pc_now = 32'h0;
    tick();
    chk("fetch_instr", ifid_instr, 32'h2009_0005);
    chk("fetch_valid", ifid_valid, 32'h1);
    chk("fetch_pcn4",  ifid_pc_next4, 32'h4);
    chk("fetch_jump",  jump, 32'h0);

    // Load-use on rt of add $3,$1,$2
    instruction = 32'h0022_1820; pc_next4 = 32'h8; pc_now = 32'h4;
    tick();
    instruction = 32'h1111_1111; pc_next4 = 32'hC; pc_now = 32'h8;
    idex_memread = 1'b1; idex_rt = 5'd2; #1;
    chk("hz_pcwrite", pc_write, 32'h0);
    chk("hz_valid",   ifid_valid, 32'h0);
    tick();
    chk("hz_hold_ins", ifid_instr, 32'h0022_1820);
    chk("hz_hold_pc",  ifid_pc_now, 32'h4);
    idex_rt = 5'd0; #1;
    chk("rt0_pcwrite", pc_write, 32'h1);
    chk("rt0_valid",   ifid_valid, 32'h1);

    // j 0x100
    idex_memread = 1'b0;
    instruction = 32'h0800_0040; pc_next4 = 32'h1000_0008; pc_now = 32'h1000_0004;
    tick();
    chk("j_jump",  jump, 32'h1);
    chk("j_newpc", new_pc, 32'h1000_0100);
    instruction = 32'h2222_2222; pc_next4 = 32'h1000_000C; pc_now = 32'h1000_0008;
    tick();
    chk("j_sq_valid", ifid_valid, 32'h0);
    chk("j_sq_instr", ifid_instr, 32'h0);
    chk("j_sq_pc",    ifid_pc_now, 32'h1000_0004);
    chk("j_sq_jump",  jump, 32'h0);

    // jal with different upper PC bits
    instruction = 32'h0C00_0001; pc_next4 = 32'hF000_0000; pc_now = 32'hEFFF_FFFC;
    tick();
    chk("jal_newpc", new_pc, 32'hF000_0004);
    chk("jal_jump",  jump, 32'h1);

    // jr $31 after squash of the jal wrong path
    instruction = 32'h03E0_0008; pc_next4 = 32'h20; pc_now = 32'h1C; rs_data = 32'h400;
    tick();
    tick();
    chk("jr_instr", ifid_instr, 32'h03E0_0008);
    chk("jr_jump",  jump, 32'h1);
    chk("jr_newpc", new_pc, 32'h400);
    idex_memread = 1'b1; idex_rt = 5'd31; #1;
    chk("jrhz_jump",    jump, 32'h0);
    chk("jrhz_pcwrite", pc_write, 32'h0);
    tick();
    chk("jrhz_hold", ifid_instr, 32'h03E0_0008);
    idex_memread = 1'b0; idex_rt = 5'd0; #1;
    chk("jrhz_clear", jump, 32'h1);

    // Freeze overrides flush
    freeze = 1'b1; flush = 1'b1; #1;
    chk("frz_jump",    jump, 32'h0);
    chk("frz_pcwrite", pc_write, 32'h0);
    tick();
    chk("frz_instr", ifid_instr, 32'h03E0_0008);
    chk("frz_valid", ifid_valid, 32'h1);
    freeze = 1'b0;
    tick();
    chk("fl_valid", ifid_valid, 32'h0);
    chk("fl_instr", ifid_instr, 32'h0);

    // Flush wins over hazard
    flush = 1'b0; instruction = 32'h0022_1820;
    tick();
    idex_memread = 1'b1; idex_rt = 5'd1; flush = 1'b1; #1;
    chk("flhz_pcwrite", pc_write, 32'h0);
    tick();
    chk("flhz_valid", ifid_valid, 32'h0);
    chk("flhz_instr", ifid_instr, 32'h0);

    // Reset while a jump is pending
    flush = 1'b0; idex_memread = 1'b0; idex_rt = 5'd0;
    instruction = 32'h0800_0040; pc_next4 = 32'h1000_0008; pc_now = 32'h1000_0004;
    tick();
    chk("prerst_jump", jump, 32'h1);
    rst = 1'b1;
    tick();
    chk("midrst_jump",  jump, 32'h0);
    chk("midrst_valid", ifid_valid, 32'h0);
    chk("midrst_pc",    ifid_pc_next4, 32'h0);
    chk("midrst_newpc", new_pc, 32'h0);

`ifdef IFID_PERF_CNT_EN
    chk("cnt_rst", stall_cnt, 32'h0);
    rst = 1'b0; instruction = 32'h0022_1820;
    tick();
    idex_memread = 1'b1; idex_rt = 5'd2;
    tick(); tick(); tick();
    chk("cnt_hz3", stall_cnt, 32'd3);
    idex_memread = 1'b0; idex_rt = 5'd0; instruction = 32'h0800_0040;
    tick();
    instruction = 32'h0;
    tick();
    chk("cnt_total", stall_cnt, 32'd4);
    chk("cnt_sat", {30'h0, stall_cnt_small}, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
